// File: rtl/mp1_wbuf_pkg.sv
// Shared types for the mp1 posted-write buffer: one queued CPU write and the drain/read FSM states.
package mp1_wbuf_pkg;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } wbuf_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2,
      RDONE = 2'd3
   } wbuf_state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular buffer of queued writes; push-when-full and pop-when-empty are silently dropped.
module wbuf_fifo
   import mp1_wbuf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  wbuf_entry_t              i_data,
   input  logic                     i_pop,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output wbuf_entry_t              o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   wbuf_entry_t   r_mem [DEPTH];
   logic          w_doPush;
   logic          w_doPop;

   assign o_full   = (r_count == CNT_FULL);
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_head   = r_mem[r_head];
   assign w_doPush = i_push & ~o_full;
   assign w_doPop  = i_pop & ~o_empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_tail <= r_tail + PTR_ONE;
         if (w_doPop)  r_head <= r_head + PTR_ONE;
         if (w_doPush && !w_doPop)      r_count <= r_count + CNT_ONE;
         else if (w_doPop && !w_doPush) r_count <= r_count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_tail] <= i_data;
   end

endmodule

// File: rtl/mp1_write_buffer.sv
// Posted-write buffer: CPU writes are acked once queued and drained to memory in order;
// reads go to memory only once the queue is empty, which keeps read-after-write ordering.
module mp1_write_buffer
   import mp1_wbuf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [1:0]  cpu_byte_enable,
   input  logic [15:0] cpu_address,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_resp,
   output logic [15:0] cpu_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  mem_byte_enable,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   input  logic        mem_resp,
   input  logic [15:0] mem_rdata
);

   localparam int CW = $clog2(DEPTH) + 1;

   wbuf_state_t r_state;
   logic        r_cpuResp;
   logic [15:0] r_cpuRdata;
   logic        r_memRead;
   logic        r_memWrite;
   logic [1:0]  r_memBe;
   logic [15:0] r_memAddr;
   logic [15:0] r_memWdata;

   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   wbuf_entry_t   w_head;
   wbuf_entry_t   w_pushEntry;
   logic          w_accept;
   logic          w_pop;

   // The ~r_cpuResp term stops a still-held cpu_write from being queued twice.
   assign w_accept    = cpu_write & ~r_cpuResp & ~w_full;
   assign w_pop       = (r_state == DRAIN) & mem_resp;
   assign w_pushEntry = '{addr: cpu_address, data: cpu_wdata, be: cpu_byte_enable};

   wbuf_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept),
      .i_data  (w_pushEntry),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_head  (w_head)
   );

   // Every mem_* output is a register, so the drop back to IDLE after each drain
   // guarantees the memory sees mem_write low between consecutive writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cpuResp  <= 1'b0;
         r_cpuRdata <= '0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
         r_memBe    <= '0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
      end else begin
         r_cpuResp <= w_accept;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_state    <= DRAIN;
                  r_memWrite <= 1'b1;
                  r_memAddr  <= w_head.addr;
                  r_memWdata <= w_head.data;
                  r_memBe    <= w_head.be;
               end else if (w_count == '0 && cpu_read && !cpu_write && !r_cpuResp) begin
                  r_state   <= READ;
                  r_memRead <= 1'b1;
                  r_memAddr <= cpu_address;
                  r_memBe   <= 2'b11;
               end
            end
            DRAIN: begin
               if (mem_resp) begin
                  r_state    <= IDLE;
                  r_memWrite <= 1'b0;
                  r_memAddr  <= '0;
                  r_memWdata <= '0;
                  r_memBe    <= '0;
               end
            end
            READ: begin
               if (mem_resp) begin
                  r_state    <= RDONE;
                  r_cpuRdata <= mem_rdata;
                  r_cpuResp  <= 1'b1;
                  r_memRead  <= 1'b0;
                  r_memAddr  <= '0;
                  r_memBe    <= '0;
               end
            end
            RDONE: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cpu_resp        = r_cpuResp;
   assign cpu_rdata       = r_cpuRdata;
   assign mem_read        = r_memRead;
   assign mem_write       = r_memWrite;
   assign mem_byte_enable = r_memBe;
   assign mem_address     = r_memAddr;
   assign mem_wdata       = r_memWdata;

endmodule

// File: tb/tb_mp1_write_buffer.sv
// Bench for mp1_write_buffer: a latency-configurable memory model with a write scoreboard,
// and a reference memory image that predicts read data.
module tb_mp1_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_read;
   logic        cpu_write;
   logic [1:0]  cpu_byte_enable;
   logic [15:0] cpu_address;
   logic [15:0] cpu_wdata;
   logic        cpu_resp;
   logic [15:0] cpu_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic        mem_resp;
   logic [15:0] mem_rdata;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } wr_t;

   int          errors = 0;
   int          checks = 0;
   int          memLatency = 2;
   int          writesDone = 0;
   logic [15:0] memArr [logic [15:0]];
   logic [15:0] refMem [logic [15:0]];
   wr_t         expWrites [$];
   logic [15:0] expReads [$];

   always #5 clk = ~clk;

   mp1_write_buffer #(.DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .cpu_read        (cpu_read),
      .cpu_write       (cpu_write),
      .cpu_byte_enable (cpu_byte_enable),
      .cpu_address     (cpu_address),
      .cpu_wdata       (cpu_wdata),
      .cpu_resp        (cpu_resp),
      .cpu_rdata       (cpu_rdata),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata)
   );

   function automatic logic [15:0] refRead(input logic [15:0] a);
      return refMem.exists(a) ? refMem[a] : 16'h0000;
   endfunction

   function automatic logic [15:0] mergeBytes(input logic [15:0] old, input logic [15:0] d,
                                              input logic [1:0] be);
      return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
   endfunction

   // Memory model: answers each request memLatency cycles after it appears and
   // retires writes against the scoreboard in CPU issue order.
   initial begin
      int          waitCount;
      wr_t         e;
      logic [15:0] old;
      mem_resp  = 1'b0;
      mem_rdata = 16'h0000;
      waitCount = 0;
      forever begin
         @(posedge clk); #1;
         if (mem_resp) begin
            mem_resp = 1'b0;
         end else if (mem_read || mem_write) begin
            waitCount++;
            if (waitCount >= memLatency) begin
               waitCount = 0;
               mem_resp  = 1'b1;
               if (mem_write) begin
                  checks++;
                  if (expWrites.size() == 0) begin
                     errors++;
                     $display("[TB] FAIL unexpected_mem_write: got addr %h data %h, required no write",
                              mem_address, mem_wdata);
                  end else begin
                     e = expWrites.pop_front();
                     if (mem_address !== e.addr || mem_wdata !== e.data || mem_byte_enable !== e.be) begin
                        errors++;
                        $display("[TB] FAIL mem_write_order: got %h/%h/%b required %h/%h/%b",
                                 mem_address, mem_wdata, mem_byte_enable, e.addr, e.data, e.be);
                     end
                  end
                  old = memArr.exists(mem_address) ? memArr[mem_address] : 16'h0000;
                  memArr[mem_address] = mergeBytes(old, mem_wdata, mem_byte_enable);
                  writesDone++;
               end else begin
                  mem_rdata = memArr.exists(mem_address) ? memArr[mem_address] : 16'h0000;
               end
            end
         end else begin
            waitCount = 0;
         end
      end
   end

   task automatic cpuWrite(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                           output int ack);
      wr_t e;
      if (cpu_resp) begin @(posedge clk); #1; end
      cpu_write       = 1'b1;
      cpu_address     = a;
      cpu_wdata       = d;
      cpu_byte_enable = be;
      e.addr = a; e.data = d; e.be = be;
      expWrites.push_back(e);
      refMem[a] = mergeBytes(refRead(a), d, be);
      ack = 0;
      do begin
         @(posedge clk); #1;
         ack++;
      end while (!cpu_resp && ack < 200);
      cpu_write = 1'b0;
   endtask

   task automatic cpuRead(input logic [15:0] a, output logic [15:0] data,
                          output bit gotResp, output bit earlyRead);
      int cyc;
      if (cpu_resp) begin @(posedge clk); #1; end
      expReads.push_back(refRead(a));
      cpu_read    = 1'b1;
      cpu_address = a;
      earlyRead   = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (mem_read && expWrites.size() != 0) earlyRead = 1'b1;
      end while (!cpu_resp && cyc < 300);
      gotResp  = cpu_resp;
      data     = cpu_rdata;
      cpu_read = 1'b0;
   endtask

   task automatic waitDrained(output bit ok);
      int cyc = 0;
      while ((expWrites.size() != 0 || mem_write || mem_read) && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      ok = (expWrites.size() == 0 && !mem_write && !mem_read);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte_enable = 2'b00;
      cpu_address = 16'h0000; cpu_wdata = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({cpu_resp, cpu_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got resp=%b rdata=%h mr=%b mw=%b be=%b addr=%h wdata=%h, required all 0",
                  cpu_resp, cpu_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata);
      end
      checks++;
      if (dut.w_count !== '0) begin
         errors++;
         $display("[TB] FAIL reset_count: got %0d required 0", dut.w_count);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({mem_read, mem_write} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: cycle %0d got mr=%b mw=%b required 0", i, mem_read, mem_write);
         end
      end
   endtask

   task automatic test_single_write();
      int ack;
      int cyc;
      bit ok;
      memLatency = 3;
      cpuWrite(16'h0010, 16'hBEEF, 2'b11, ack);
      checks++;
      if (ack !== 1) begin
         errors++;
         $display("[TB] FAIL single_write_ack: got %0d cycles required 1", ack);
      end
      cyc = 0;
      while (!mem_write && cyc < 20) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (mem_write !== 1'b1 || mem_address !== 16'h0010 || mem_wdata !== 16'hBEEF || mem_byte_enable !== 2'b11) begin
         errors++;
         $display("[TB] FAIL single_write_req: got mw=%b %h/%h/%b required 1 0010/beef/11",
                  mem_write, mem_address, mem_wdata, mem_byte_enable);
      end
      waitDrained(ok);
      checks++;
      if (!ok || memArr[16'h0010] !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL single_write_mem: got drained=%b word=%h required 1 beef", ok, memArr[16'h0010]);
      end
   endtask

   task automatic test_back_to_back();
      int ack;
      int doneBefore;
      bit ok;
      memLatency = 10;
      for (int i = 0; i < 4; i++) begin
         cpuWrite(16'h0100 + 16'(2 * i), 16'hC000 + 16'(i), 2'b11, ack);
         checks++;
         if (ack !== 1) begin
            errors++;
            $display("[TB] FAIL b2b_ack_%0d: got %0d cycles required 1", i, ack);
         end
      end
      doneBefore = writesDone;
      cpuWrite(16'h0108, 16'hC004, 2'b11, ack);
      checks++;
      if (ack <= 1 || ack >= 200 || doneBefore != writesDone - 1 - (writesDone - doneBefore - 1)) begin
         errors++;
         $display("[TB] FAIL b2b_full_stall: got ack %0d cycles required >1 and <200", ack);
      end
      checks++;
      if (writesDone - doneBefore < 1) begin
         errors++;
         $display("[TB] FAIL b2b_ack_before_resp: got %0d retired writes at ack, required >=1",
                  writesDone - doneBefore);
      end
      waitDrained(ok);
      checks++;
      if (!ok || memArr[16'h0108] !== 16'hC004) begin
         errors++;
         $display("[TB] FAIL b2b_drain: got drained=%b last=%h required 1 c004", ok, memArr[16'h0108]);
      end
      memLatency = 2;
   endtask

   task automatic test_read_after_write();
      int          ack;
      logic [15:0] data;
      logic [15:0] exp;
      bit          got;
      bit          early;
      cpuWrite(16'h0020, 16'h1234, 2'b11, ack);
      cpuRead(16'h0020, data, got, early);
      exp = expReads.pop_front();
      checks++;
      if (early) begin
         errors++;
         $display("[TB] FAIL raw_order: got mem_read with writes pending, required none");
      end
      checks++;
      if (!got || data !== exp) begin
         errors++;
         $display("[TB] FAIL raw_data: got resp=%b rdata=%h required 1 %h", got, data, exp);
      end
   endtask

   task automatic test_byte_enable();
      int          ack;
      logic [15:0] data;
      logic [15:0] exp;
      bit          got;
      bit          early;
      memArr[16'h0030] = 16'hFFFF;
      refMem[16'h0030] = 16'hFFFF;
      cpuWrite(16'h0030, 16'hAB55, 2'b01, ack);
      cpuRead(16'h0030, data, got, early);
      exp = expReads.pop_front();
      checks++;
      if (!got || data !== exp || exp !== 16'hFF55) begin
         errors++;
         $display("[TB] FAIL byte_enable: got resp=%b rdata=%h required 1 ff55", got, data);
      end
   endtask

   task automatic test_reset_mid_drain();
      int          ack;
      int          cyc;
      int          doneBefore;
      logic [15:0] data;
      logic [15:0] exp;
      bit          got;
      bit          early;
      memLatency = 10;
      for (int i = 0; i < 3; i++) begin
         memArr[16'h0040 + 16'(2 * i)] = 16'h1111 * 16'(i + 1);
         refMem[16'h0040 + 16'(2 * i)] = 16'h1111 * 16'(i + 1);
      end
      doneBefore = writesDone;
      cpuWrite(16'h0040, 16'hAAAA, 2'b11, ack);
      cpuWrite(16'h0042, 16'hBBBB, 2'b11, ack);
      cpuWrite(16'h0044, 16'hCCCC, 2'b11, ack);
      cyc = 0;
      while (!mem_write && cyc < 20) begin @(posedge clk); #1; cyc++; end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (mem_write !== 1'b0 || dut.w_count !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_drain: got mw=%b count=%0d required 0 0", mem_write, dut.w_count);
      end
      rst = 1'b0;
      expWrites.delete();
      for (int i = 0; i < 3; i++) refMem[16'h0040 + 16'(2 * i)] = 16'h1111 * 16'(i + 1);
      memLatency = 2;
      for (int i = 1; i < 3; i++) begin
         cpuRead(16'h0040 + 16'(2 * i), data, got, early);
         exp = expReads.pop_front();
         checks++;
         if (!got || data !== exp) begin
            errors++;
            $display("[TB] FAIL discarded_write_%0d: got resp=%b rdata=%h required 1 %h", i, got, data, exp);
         end
      end
      checks++;
      if (writesDone !== doneBefore) begin
         errors++;
         $display("[TB] FAIL discarded_count: got %0d writes retired required 0", writesDone - doneBefore);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_read_after_write();
      test_byte_enable();
      test_reset_mid_drain();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
